// File: rtl/top_mac_pkg.sv
// top_mac_pkg: shared types and constants for the SDA multiply-accumulate stage.
//   - datapath widths (weight, activation, product, accumulator, result)
//   - FSM state encoding shared by the top level and the bench
//   - signed result limits used for range detection and saturation
// Build option: TOP_MAC_SAT_EN (see top_mac_acc_2ns_32s) does not affect this file.
package top_mac_pkg;

    localparam int W_WIDTH    = 2;
    localparam int A_WIDTH    = 32;
    localparam int LEN_WIDTH  = 16;
    localparam int ACC_WIDTH  = 50;
    localparam int OUT_WIDTH  = 32;
    localparam int PROD_WIDTH = W_WIDTH + A_WIDTH;

    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // A signed accumulator value fits the signed result width exactly when
    // every bit from the result sign bit upward is a copy of the same value.
    function automatic logic out_fits(input logic [ACC_WIDTH-1:0] v);
        return (&v[ACC_WIDTH-1:OUT_WIDTH-1]) | ~(|v[ACC_WIDTH-1:OUT_WIDTH-1]);
    endfunction

endpackage

// File: rtl/top_mac_prod_reg.sv
// top_mac_prod_reg: stage-1 product register of the MAC stage.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   accept      an operand pair is being accepted this edge
//   w, a        unsigned weight, signed activation
//   p           registered signed product (PROD_WIDTH bits)
//   p_valid     p holds the product of a beat accepted on the previous edge
module top_mac_prod_reg
    import top_mac_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         accept,
    input  logic [W_WIDTH-1:0]           w,
    input  logic [A_WIDTH-1:0]           a,
    output logic signed [PROD_WIDTH-1:0] p,
    output logic                         p_valid
);

    // Zero-extending the weight by one bit lets it take part in a signed
    // multiply without being misread as negative.
    logic signed [PROD_WIDTH-1:0] prod_c;
    assign prod_c = $signed({1'b0, w}) * $signed(a);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p       <= '0;
            p_valid <= 1'b0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p <= prod_c;
            end
        end
    end

endmodule

// File: rtl/top_mac_acc_2ns_32s.sv
// top_mac_acc_2ns_32s: multiply-accumulate stage of the SDA datapath.
// Takes cfg_len (2-bit unsigned weight, 32-bit signed activation) pairs,
// multiplies them in a registered stage, sums the products and emits one
// 32-bit dot-product per job.
// Ports:
//   ap_clk, ap_rst        clock, asynchronous active-high reset
//   start, cfg_len        job launch (sampled in IDLE) and product count
//   busy                  high whenever the FSM is not IDLE
//   in_valid/in_ready     operand input handshake; in_w, in_a operands
//   out_valid/out_ready   result handshake; out_data result, out_ovf range flag
//   dbg_state             current FSM state (state_t encoding)
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid && ready; ready never depends combinationally on valid, and a
// valid output holds its payload stable until it is accepted.
// Build option: define TOP_MAC_SAT_EN to saturate out_data when out_ovf is
// set; otherwise out_data is the low 32 bits of the sum.
module top_mac_acc_2ns_32s
    import top_mac_pkg::*;
(
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_WIDTH-1:0]   in_w,
    input  logic [A_WIDTH-1:0]   in_a,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    output logic [1:0]           dbg_state
);

    state_t                       state, state_n;
    logic [LEN_WIDTH-1:0]         len;
    logic [LEN_WIDTH-1:0]         count;
    logic [ACC_WIDTH-1:0]         acc;
    logic signed [PROD_WIDTH-1:0] p;
    logic                         p_valid;
    logic                         accept;
    logic                         job_start;
    logic                         last_prod;

    assign in_ready  = (state == RUN) && (count != len);
    assign accept    = in_valid && in_ready;
    assign job_start = (state == IDLE) && start;
    // count reaches len on the edge that accepts the final beat, so the
    // first cycle with p_valid and count == len carries that beat's product.
    assign last_prod = p_valid && (count == len);

    top_mac_prod_reg u_prod (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .accept  (accept),
        .w       (in_w),
        .a       (in_a),
        .p       (p),
        .p_valid (p_valid)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = (cfg_len == '0) ? OUT : RUN;
                end
            end
            RUN: begin
                if (last_prod) begin
                    state_n = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            len   <= '0;
            count <= '0;
            acc   <= '0;
        end else if (job_start) begin
            len   <= cfg_len;
            count <= '0;
            acc   <= '0;
        end else begin
            if (accept) begin
                count <= count + LEN_WIDTH'(1);
            end
            if (p_valid) begin
                acc <= acc + {{(ACC_WIDTH-PROD_WIDTH){p[PROD_WIDTH-1]}}, p};
            end
        end
    end

    // Result formatting. acc is frozen in OUT, so the payload is stable
    // for as long as out_valid waits for out_ready.
    logic                 ovf_c;
    logic [OUT_WIDTH-1:0] fmt_c;

    assign ovf_c = ~out_fits(acc);

`ifdef TOP_MAC_SAT_EN
    assign fmt_c = ovf_c ? (acc[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX) : acc[OUT_WIDTH-1:0];
`else
    assign fmt_c = acc[OUT_WIDTH-1:0];
`endif

    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);
    assign out_ovf   = out_valid & ovf_c;
    assign out_data  = out_valid ? fmt_c : '0;
    assign dbg_state = state;

endmodule
